// File: rtl/object_readout_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// object_readout_ctrl
// End-of-frame sequencer for connected-components labelling. Walks labels
// 1..num_labels-1, keeps only roots of the merge table (mt[L]==L) whose
// accumulated area reaches MIN_AREA, divides the x/y accumulators by the area
// with a shared restoring divider (one quotient bit per cycle) and emits one
// centroid record per object over a valid/ready stream.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start, num_labels    frame-done pulse (IDLE only) and next free label
//   mt_addr / mt_data    merge-table read port, 1-cycle read latency
//   dt_addr / dt_data    data-table read port {y_acc, x_acc, p_acc}, 1-cycle
//   busy                 high while this block owns both table read ports
//   done                 one-cycle pulse at the end of the scan
//   obj_valid/obj_ready  record handshake
//   obj_id/x/y/area      root label, floor(x/p), floor(y/p), saturated p
// -----------------------------------------------------------------------------
module object_readout_ctrl #(
    parameter int WORD_SIZE   = 8,
    parameter int OBJ_WIDTH   = 128,
    parameter int DIV_WIDTH   = 64,
    parameter int COORD_WIDTH = 32,
    parameter int MIN_AREA    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WORD_SIZE-1:0]     num_labels,
    output logic [WORD_SIZE-1:0]     mt_addr,
    input  logic [WORD_SIZE-1:0]     mt_data,
    output logic [WORD_SIZE-1:0]     dt_addr,
    input  logic [3*OBJ_WIDTH-1:0]   dt_data,
    output logic                     busy,
    output logic                     done,
    output logic                     obj_valid,
    input  logic                     obj_ready,
    output logic [WORD_SIZE-1:0]     obj_id,
    output logic [COORD_WIDTH-1:0]   obj_x,
    output logic [COORD_WIDTH-1:0]   obj_y,
    output logic [COORD_WIDTH-1:0]   obj_area
);

    localparam int CNT_W = $clog2(DIV_WIDTH + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(DIV_WIDTH - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0]   LBL_ONE    = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [OBJ_WIDTH-1:0]   MIN_AREA_W = OBJ_WIDTH'(MIN_AREA);
    localparam logic [COORD_WIDTH-1:0] COORD_MAX  = {COORD_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE, MT_RD, MT_CHK, DT_RD, DT_CHK, DIV, OUT, FIN
    } state_t;

    // Quotient clamp: anything not representable in COORD_WIDTH bits becomes all-ones.
    function automatic logic [COORD_WIDTH-1:0] sat_quot(input logic [DIV_WIDTH-1:0] q);
        if ((q >> COORD_WIDTH) != {DIV_WIDTH{1'b0}}) begin
            sat_quot = COORD_MAX;
        end else begin
            sat_quot = q[COORD_WIDTH-1:0];
        end
    endfunction

    // Area clamp from the full accumulator width down to COORD_WIDTH.
    function automatic logic [COORD_WIDTH-1:0] sat_area(input logic [OBJ_WIDTH-1:0] p);
        if ((p >> COORD_WIDTH) != {OBJ_WIDTH{1'b0}}) begin
            sat_area = COORD_MAX;
        end else begin
            sat_area = p[COORD_WIDTH-1:0];
        end
    endfunction

    state_t                   r_state;
    logic [WORD_SIZE-1:0]     r_lbl;
    logic [WORD_SIZE-1:0]     r_num;
    logic [WORD_SIZE-1:0]     r_mt_addr;
    logic [WORD_SIZE-1:0]     r_dt_addr;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_valid;
    logic [WORD_SIZE-1:0]     r_obj_id;
    logic [COORD_WIDTH-1:0]   r_obj_x;
    logic [COORD_WIDTH-1:0]   r_obj_y;
    logic [COORD_WIDTH-1:0]   r_obj_area;
    logic [COORD_WIDTH-1:0]   r_area;
    // Divider: r_q* start as the dividend and shift into the quotient.
    logic [DIV_WIDTH-1:0]     r_dvsr;
    logic [DIV_WIDTH-1:0]     r_qx, r_qy;
    logic [DIV_WIDTH-1:0]     r_rx, r_ry;
    logic [CNT_W-1:0]         r_div_cnt;

    logic [OBJ_WIDTH-1:0]     w_p_acc;
    logic [WORD_SIZE-1:0]     w_lbl_inc;
    logic                     w_last_lbl;
    logic [DIV_WIDTH:0]       w_dvsr_ext;
    logic [DIV_WIDTH:0]       w_shx, w_shy;
    logic [DIV_WIDTH-1:0]     w_rx_nxt, w_ry_nxt;
    logic [DIV_WIDTH-1:0]     w_qx_nxt, w_qy_nxt;
    logic                     w_unused_dt;

    assign w_p_acc    = dt_data[OBJ_WIDTH-1:0];
    assign w_lbl_inc  = r_lbl + LBL_ONE;
    assign w_last_lbl = (w_lbl_inc == r_num);
    // Accumulator bits above DIV_WIDTH never reach the divider.
    assign w_unused_dt = &{1'b0,
                           dt_data[2*OBJ_WIDTH-1:OBJ_WIDTH+DIV_WIDTH],
                           dt_data[3*OBJ_WIDTH-1:2*OBJ_WIDTH+DIV_WIDTH]};

    // One restoring-division step for x and y in parallel.
    always_comb begin
        w_dvsr_ext = {1'b0, r_dvsr};
        w_shx      = {r_rx, r_qx[DIV_WIDTH-1]};
        w_shy      = {r_ry, r_qy[DIV_WIDTH-1]};
        // The true difference is below the divisor, so DIV_WIDTH-bit subtraction is exact.
        if (w_shx >= w_dvsr_ext) begin
            w_rx_nxt = w_shx[DIV_WIDTH-1:0] - r_dvsr;
            w_qx_nxt = {r_qx[DIV_WIDTH-2:0], 1'b1};
        end else begin
            w_rx_nxt = w_shx[DIV_WIDTH-1:0];
            w_qx_nxt = {r_qx[DIV_WIDTH-2:0], 1'b0};
        end
        if (w_shy >= w_dvsr_ext) begin
            w_ry_nxt = w_shy[DIV_WIDTH-1:0] - r_dvsr;
            w_qy_nxt = {r_qy[DIV_WIDTH-2:0], 1'b1};
        end else begin
            w_ry_nxt = w_shy[DIV_WIDTH-1:0];
            w_qy_nxt = {r_qy[DIV_WIDTH-2:0], 1'b0};
        end
    end

    // Scan FSM, divider state and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_lbl      <= LBL_ONE;
            r_num      <= {WORD_SIZE{1'b0}};
            r_mt_addr  <= {WORD_SIZE{1'b0}};
            r_dt_addr  <= {WORD_SIZE{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_obj_id   <= {WORD_SIZE{1'b0}};
            r_obj_x    <= {COORD_WIDTH{1'b0}};
            r_obj_y    <= {COORD_WIDTH{1'b0}};
            r_obj_area <= {COORD_WIDTH{1'b0}};
            r_area     <= {COORD_WIDTH{1'b0}};
            r_dvsr     <= {DIV_WIDTH{1'b0}};
            r_qx       <= {DIV_WIDTH{1'b0}};
            r_qy       <= {DIV_WIDTH{1'b0}};
            r_rx       <= {DIV_WIDTH{1'b0}};
            r_ry       <= {DIV_WIDTH{1'b0}};
            r_div_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num  <= num_labels;
                        r_lbl  <= LBL_ONE;
                        r_busy <= 1'b1;
                        if (num_labels <= LBL_ONE) begin
                            r_state <= FIN;
                        end else begin
                            // Address is registered on entry so the RAM sees it during MT_RD.
                            r_mt_addr <= LBL_ONE;
                            r_state   <= MT_RD;
                        end
                    end
                end
                MT_RD: begin
                    r_mt_addr <= r_lbl;
                    r_state   <= MT_CHK;
                end
                MT_CHK: begin
                    if (mt_data != r_lbl) begin
                        r_lbl <= w_lbl_inc;
                        if (w_last_lbl) begin
                            r_state <= FIN;
                        end else begin
                            r_mt_addr <= w_lbl_inc;
                            r_state   <= MT_RD;
                        end
                    end else begin
                        r_dt_addr <= r_lbl;
                        r_state   <= DT_RD;
                    end
                end
                DT_RD: begin
                    r_state <= DT_CHK;
                end
                DT_CHK: begin
                    if ((w_p_acc == {OBJ_WIDTH{1'b0}}) || (w_p_acc < MIN_AREA_W)) begin
                        r_lbl <= w_lbl_inc;
                        if (w_last_lbl) begin
                            r_state <= FIN;
                        end else begin
                            r_mt_addr <= w_lbl_inc;
                            r_state   <= MT_RD;
                        end
                    end else begin
                        r_qx      <= dt_data[OBJ_WIDTH+DIV_WIDTH-1:OBJ_WIDTH];
                        r_qy      <= dt_data[2*OBJ_WIDTH+DIV_WIDTH-1:2*OBJ_WIDTH];
                        r_dvsr    <= dt_data[DIV_WIDTH-1:0];
                        r_rx      <= {DIV_WIDTH{1'b0}};
                        r_ry      <= {DIV_WIDTH{1'b0}};
                        r_div_cnt <= {CNT_W{1'b0}};
                        r_area    <= sat_area(w_p_acc);
                        r_state   <= DIV;
                    end
                end
                DIV: begin
                    r_rx <= w_rx_nxt;
                    r_ry <= w_ry_nxt;
                    r_qx <= w_qx_nxt;
                    r_qy <= w_qy_nxt;
                    // Last step: publish straight from the final quotient bits.
                    if (r_div_cnt == CNT_LAST) begin
                        r_obj_id   <= r_lbl;
                        r_obj_x    <= sat_quot(w_qx_nxt);
                        r_obj_y    <= sat_quot(w_qy_nxt);
                        r_obj_area <= r_area;
                        r_valid    <= 1'b1;
                        r_state    <= OUT;
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_ONE;
                    end
                end
                OUT: begin
                    if (r_valid && obj_ready) begin
                        r_valid <= 1'b0;
                        r_lbl   <= w_lbl_inc;
                        if (w_last_lbl) begin
                            r_state <= FIN;
                        end else begin
                            r_mt_addr <= w_lbl_inc;
                            r_state   <= MT_RD;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mt_addr   = r_mt_addr;
    assign dt_addr   = r_dt_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign obj_valid = r_valid;
    assign obj_id    = r_obj_id;
    assign obj_x     = r_obj_x;
    assign obj_y     = r_obj_y;
    assign obj_area  = r_obj_area;

endmodule

// File: tb/tb_object_readout_ctrl.sv
`timescale 1ns/1ps
// Bench for object_readout_ctrl: two instances (MIN_AREA 1 and 5) read the same
// table contents; a label-level model builds the expected record list per
// instance and one negedge process checks every valid cycle against it.
module tb_object_readout_ctrl;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] area;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         obj_ready = 1'b0;
    logic [7:0]   num_labels = 8'd0;

    logic [7:0]   mt_addr0, mt_addr1, mt_data0, mt_data1, dt_addr0, dt_addr1;
    logic [383:0] dt_data0, dt_data1;
    logic         busy0, busy1, done0, done1, v0, v1;
    logic [7:0]   id0, id1;
    logic [31:0]  x0, y0, a0, x1, y1, a1;

    logic [7:0]   mt_mem [256];
    logic [383:0] dt_mem [256];
    rec_t         q0[$];
    rec_t         q1[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    object_readout_ctrl u_dut0 (
        .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
        .mt_addr(mt_addr0), .mt_data(mt_data0), .dt_addr(dt_addr0), .dt_data(dt_data0),
        .busy(busy0), .done(done0), .obj_valid(v0), .obj_ready(obj_ready),
        .obj_id(id0), .obj_x(x0), .obj_y(y0), .obj_area(a0));

    object_readout_ctrl #(.MIN_AREA(5)) u_dut5 (
        .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
        .mt_addr(mt_addr1), .mt_data(mt_data1), .dt_addr(dt_addr1), .dt_data(dt_data1),
        .busy(busy1), .done(done1), .obj_valid(v1), .obj_ready(obj_ready),
        .obj_id(id1), .obj_x(x1), .obj_y(y1), .obj_area(a1));

    always #5 clk = ~clk;

    // Synchronous-read table models, one read port per instance.
    always @(posedge clk) begin
        mt_data0 <= mt_mem[mt_addr0];
        dt_data0 <= dt_mem[dt_addr0];
        mt_data1 <= mt_mem[mt_addr1];
        dt_data1 <= dt_mem[dt_addr1];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_rec(input string tag, input rec_t e, input rec_t a);
        chk({tag, " id"},   128'(a.id),   128'(e.id));
        chk({tag, " x"},    128'(a.x),    128'(e.x));
        chk({tag, " y"},    128'(a.y),    128'(e.y));
        chk({tag, " area"}, 128'(a.area), 128'(e.area));
    endtask

    function automatic logic [31:0] quot(input logic [127:0] n, input logic [127:0] d);
        logic [63:0] nn, dd, q;
        nn = n[63:0];
        dd = d[63:0];
        if (dd == 64'd0) return 32'hFFFF_FFFF;
        q = nn / dd;
        if (q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return q[31:0];
    endfunction

    // Expected records: every root label in order whose area is nonzero and >= min_area.
    task automatic build_exp(input int num, input int min_area, input bit second);
        logic [127:0] p, xa, ya;
        rec_t r;
        for (int l = 1; l < num; l++) begin
            if (mt_mem[l] == 8'(l)) begin
                p  = dt_mem[l][127:0];
                xa = dt_mem[l][255:128];
                ya = dt_mem[l][383:256];
                if (p != 128'd0 && p >= 128'(min_area)) begin
                    r.id   = 8'(l);
                    r.x    = quot(xa, p);
                    r.y    = quot(ya, p);
                    r.area = (p > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
                    if (second) q1.push_back(r);
                    else        q0.push_back(r);
                end
            end
        end
    endtask

    task automatic build_both(input int num);
        build_exp(num, 1, 1'b0);
        build_exp(num, 5, 1'b1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mt_mem[i] = 8'd0;
            dt_mem[i] = 384'd0;
        end
    endtask

    task automatic set_obj(input int l, input logic [127:0] p, input logic [127:0] x,
                           input logic [127:0] y);
        dt_mem[l] = {y, x, p};
    endtask

    // Returns 1 ns after the edge that samples start; num_labels is then scrambled.
    task automatic pulse_start(input logic [7:0] n);
        @(posedge clk); #1;
        num_labels = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num_labels = 8'd0;
    endtask

    task automatic wait_done(input string tag, input int t0, input int t1);
        int n;
        n = 0;
        while ((done_cnt0 < t0 || done_cnt1 < t1) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, " done reached"}, 128'(n < 5000), 128'd1);
        chk({tag, " dut0 all records"}, 128'(q0.size()), 128'd0);
        chk({tag, " dut5 all records"}, 128'(q1.size()), 128'd0);
    endtask

    // Scoreboard: every valid cycle must show the head expected record.
    always @(negedge clk) begin
        rec_t act;
        if (!reset) begin
            if (done0) done_cnt0++;
            if (done1) done_cnt1++;
            if (v0) begin
                act = {id0, x0, y0, a0};
                if (q0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL dut0 unexpected record: got id %0d, none expected", id0);
                end else begin
                    cmp_rec("dut0 rec", q0[0], act);
                    if (obj_ready) void'(q0.pop_front());
                end
            end
            if (v1) begin
                act = {id1, x1, y1, a1};
                if (q1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL dut5 unexpected record: got id %0d, none expected", id1);
                end else begin
                    cmp_rec("dut5 rec", q1[0], act);
                    if (obj_ready) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, lat;
        clear_mem();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",      128'(busy0),    128'd0);
        chk("reset done",      128'(done0),    128'd0);
        chk("reset valid",     128'(v0),       128'd0);
        chk("reset obj_x",     128'(x0),       128'd0);
        chk("reset mt_addr",   128'(mt_addr0), 128'd0);
        reset = 1'b0;

        // num_labels=1: nothing to scan.
        pulse_start(8'd1);
        chk("A busy after start", 128'(busy0), 128'd1);
        chk("A done early",       128'(done0), 128'd0);
        @(posedge clk); #1;
        chk("A busy one cycle",   128'(busy0), 128'd0);
        chk("A done pulse",       128'(done0), 128'd1);
        chk("A dut5 done pulse",  128'(done1), 128'd1);
        @(posedge clk); #1;
        chk("A done one cycle",   128'(done0), 128'd0);

        // Two roots, continuous ready.
        clear_mem();
        mt_mem[1] = 8'd1; mt_mem[2] = 8'd1; mt_mem[3] = 8'd3;
        set_obj(1, 128'd10, 128'd55, 128'd120);
        set_obj(3, 128'd4,  128'd13, 128'd7);
        obj_ready = 1'b1;
        build_both(4);
        chk("model B size",  128'(q0.size()), 128'd2);
        chk("model B rec0",  128'(q0[0]), 128'({8'd1, 32'd5, 32'd12, 32'd10}));
        chk("model B rec1",  128'(q0[1]), 128'({8'd3, 32'd3, 32'd1, 32'd4}));
        chk("model B min5",  128'(q1.size()), 128'd1);
        d0 = done_cnt0; d1 = done_cnt1;
        pulse_start(8'd4);
        lat = 0;
        while (!v0 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("B first valid latency", 128'(lat), 128'd68);
        wait_done("B", d0 + 1, d1 + 1);

        // Same tables, backpressure on record 1.
        obj_ready = 1'b0;
        build_both(4);
        d0 = done_cnt0; d1 = done_cnt1;
        pulse_start(8'd4);
        lat = 0;
        while (!v0 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("C valid held", 128'(v0), 128'd1);
            chk("C id held",    128'(id0), 128'd1);
        end
        obj_ready = 1'b1;
        wait_done("C", d0 + 1, d1 + 1);

        // Zero-area root and area saturation.
        clear_mem();
        mt_mem[1] = 8'd1; mt_mem[2] = 8'd2; mt_mem[3] = 8'd3;
        set_obj(1, 128'd0, 128'd77, 128'd88);
        set_obj(2, 128'd6, 128'd100, 128'd13);
        set_obj(3, 128'd1 << 33, 128'd1 << 34, 128'd5);
        build_both(4);
        chk("model D rec0", 128'(q0[0]), 128'({8'd2, 32'd16, 32'd2, 32'd6}));
        chk("model D rec1", 128'(q0[1]), 128'({8'd3, 32'd2, 32'd0, 32'hFFFF_FFFF}));
        d0 = done_cnt0; d1 = done_cnt1;
        pulse_start(8'd4);
        wait_done("D", d0 + 1, d1 + 1);

        // Quotient saturation, start while busy ignored.
        clear_mem();
        mt_mem[1] = 8'd1;
        set_obj(1, 128'd1, 128'd1 << 40, 128'd7);
        build_both(2);
        chk("model E x sat", 128'(q0[0].x), 128'hFFFF_FFFF);
        chk("model E min5",  128'(q1.size()), 128'd0);
        d0 = done_cnt0; d1 = done_cnt1;
        pulse_start(8'd2);
        pulse_start(8'd2);
        wait_done("E", d0 + 1, d1 + 1);
        repeat (150) @(posedge clk);
        #1;
        chk("E no rescan dut0", 128'(done_cnt0), 128'(d0 + 1));
        chk("E no rescan dut5", 128'(done_cnt1), 128'(d1 + 1));
        chk("E idle busy",      128'(busy0),     128'd0);

        // Largest label range: last scanned label is 254.
        clear_mem();
        mt_mem[254] = 8'd254;
        set_obj(254, 128'd2, 128'd9, 128'd4);
        build_both(255);
        chk("model F rec", 128'(q0[0]), 128'({8'd254, 32'd4, 32'd2, 32'd2}));
        d0 = done_cnt0; d1 = done_cnt1;
        pulse_start(8'd255);
        wait_done("F", d0 + 1, d1 + 1);

        // Asynchronous reset in the middle of the divide, then a clean rescan.
        clear_mem();
        mt_mem[1] = 8'd1; mt_mem[2] = 8'd1; mt_mem[3] = 8'd3;
        set_obj(1, 128'd10, 128'd55, 128'd120);
        set_obj(3, 128'd4,  128'd13, 128'd7);
        obj_ready = 1'b0;
        build_both(4);
        pulse_start(8'd4);
        repeat (20) @(posedge clk);
        #2;
        chk("G in divide busy", 128'(busy0), 128'd1);
        reset = 1'b1;
        #1;
        chk("G reset busy",    128'(busy0),    128'd0);
        chk("G reset valid",   128'(v0),       128'd0);
        chk("G reset mt_addr", 128'(mt_addr0), 128'd0);
        chk("G reset dt_addr", 128'(dt_addr0), 128'd0);
        chk("G reset busy5",   128'(busy1),    128'd0);
        q0.delete();
        q1.delete();
        d0 = done_cnt0; d1 = done_cnt1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("G no done", 128'(done_cnt0), 128'(d0));
        obj_ready = 1'b1;
        build_both(4);
        pulse_start(8'd4);
        lat = 0;
        while (!v0 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("G rescan latency", 128'(lat), 128'd68);
        chk("G rescan id",      128'(id0), 128'd1);
        wait_done("G", d0 + 1, d1 + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/object_readout_ctrl.md
Name: object_readout_ctrl

Overview:
- End-of-frame sequencer. Walks the merge table and the data table left behind by connected-components labelling and emits one centroid record per surviving root object over a valid/ready stream.
- While `busy` is high it owns the read ports of both tables; `busy` is the mux select that takes those ports away from the labelling pipeline.
- Centroids are computed with a shared sequential restoring divider.

Parameters:
- WORD_SIZE, 8, label/address width (label 0 reserved as background).
- OBJ_WIDTH, 128, width of each accumulated feature in the data table.
- DIV_WIDTH, 64, low accumulator bits fed to the divider; one quotient bit per cycle.
- COORD_WIDTH, 32, width of output centroid coordinates.
- MIN_AREA, 1, roots with p_acc below this are suppressed.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  frame-done pulse; sampled only in IDLE.
- num_labels  in  WORD_SIZE  next free label; valid labels are 1..num_labels-1; latched on start.
- mt_addr  out  WORD_SIZE  merge-table read address.
- mt_data  in  WORD_SIZE  resolved label; synchronous read, valid 1 cycle after mt_addr.
- dt_addr  out  WORD_SIZE  data-table read address.
- dt_data  in  3*OBJ_WIDTH  {y_acc, x_acc, p_acc}; synchronous read, 1-cycle latency.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the scan completes.
- obj_valid  out  1  record available.
- obj_ready  in  1  consumer accepts the record.
- obj_id  out  WORD_SIZE  root label.
- obj_x  out  COORD_WIDTH  floor(x_acc/p_acc).
- obj_y  out  COORD_WIDTH  floor(y_acc/p_acc).
- obj_area  out  COORD_WIDTH  p_acc, saturated to 2^COORD_WIDTH-1.

Behaviour:
- Reset (async, any state): state=IDLE, label counter L=1, all outputs 0, divider cleared. Reset mid-scan abandons the scan; no done pulse.
- States: IDLE, MT_RD, MT_CHK, DT_RD, DT_CHK, DIV, OUT, FIN.
- IDLE: on start, latch num_labels and set L=1. Go to FIN if latched num_labels<=1, else to MT_RD. start in any other state is ignored.
- MT_RD: drive mt_addr=L.
- MT_CHK: if mt_data!=L (non-root), go to NEXT; else go to DT_RD.
- DT_RD: drive dt_addr=L.
- DT_CHK: capture dt_data. If p_acc==0 or p_acc<MIN_AREA, go to NEXT; else go to DIV.
- DIV: x and y divided in parallel, using dividend = low DIV_WIDTH bits and divisor = low DIV_WIDTH bits of p_acc. Takes exactly DIV_WIDTH cycles. A quotient of 2^COORD_WIDTH or more saturates to all-ones.
- OUT: obj_valid=1 with obj_id/obj_x/obj_y/obj_area. All output fields stay stable until obj_valid&&obj_ready. Then obj_valid drops the next cycle and the FSM goes to NEXT.
- NEXT (not a state, an action): L<=L+1. Go to FIN if L+1==latched num_labels, else to MT_RD.
- FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- L arithmetic: WORD_SIZE bits. When num_labels=2^WORD_SIZE-1 the last label scanned is 2^WORD_SIZE-2; no wrap to 0.
- Latency, first root at label 1: obj_valid rises 4+DIV_WIDTH edges after the edge sampling start.
- Per-label cost: 2 cycles for a non-root, 4 cycles for a suppressed root, 5+DIV_WIDTH cycles plus backpressure for an emitted root.
- obj_ready held high continuously gives a 1-cycle handshake; obj_ready high while obj_valid is low has no effect.
- mt_addr/dt_addr hold their last value outside the read states; they are don't-care when busy=0.

Test Plan:
- Reset asserted mid-DIV with obj_ready=0 -> outputs 0 immediately (async), state IDLE; no done; a new start rescans from L=1.
- num_labels=1, start -> done pulses 2 edges later; obj_valid never asserts; busy high for exactly 1 cycle.
- num_labels=4, merge table {1->1, 2->1, 3->3}, data L1={p=10,x=55,y=120}, L3={p=4,x=13,y=7} -> exactly two records: (id1, x5, y12, area10) then (id3, x3, y1, area4); done after the second handshake.
- Same as above with obj_ready low for 7 cycles on record 1 -> obj_valid and its fields stable for 7 cycles, no record dropped or duplicated.
- MIN_AREA=5, root with p=4 -> suppressed; root with p_acc=0 -> suppressed with no divide-by-zero; done still pulses.
- x_acc=2^40, p_acc=1, DIV_WIDTH=64 -> obj_x saturates to 0xFFFFFFFF; obj_area=1; start pulsed while busy -> ignored, no rescan.
